// File: rtl/modn_updown_counter_if.sv
// Control and status bundle for the mod-N up/down counter.
// The master drives the controls and the counter (slave) returns the count and status flags.
interface modn_updown_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] din;
  logic             t;
  logic             up;
  logic             oneshot;
  logic             start;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic             ovf;

  modport master (
    output clr, load, din, t, up, oneshot, start,
    input  q, tc, busy, ovf
  );

  modport slave (
    input  clr, load, din, t, up, oneshot, start,
    output q, tc, busy, ovf
  );
endinterface

// File: rtl/modn_updown_counter.sv
// Mod-N up/down event counter with load, free-run/one-shot modes, tc pulse and sticky ovf.
// Latency: one clk from control to q/tc/busy/ovf. Backpressure: none; every edge is acted on.
module modn_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  modn_updown_counter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  state_t           state;
  state_t           state_nxt;
  logic             mode;
  logic [WIDTH-1:0] q_r;
  logic             tc_r;
  logic             ovf_r;
  logic             busy_c;

  logic             accept;
  logic             step;
  logic             at_term;
  logic             term_evt;
  logic [WIDTH-1:0] load_val;

  assign accept   = bus.start && (state != RUN);
  // A load in the same cycle wins over counting, so the step is suppressed.
  assign step     = (state == RUN) && bus.t && !bus.load;
  assign at_term  = bus.up ? (q_r == MAX_VAL) : (q_r == '0);
  assign term_evt = step && at_term;
  assign load_val = ({1'b0, bus.din} >= MOD_EXT) ? MAX_VAL : bus.din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (bus.clr) begin
      state_nxt = IDLE;
    end else if (accept) begin
      state_nxt = RUN;
    end else if (term_evt && mode) begin
      state_nxt = DONE;
    end
  end

  always_comb begin
    busy_c = (state == RUN);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
      mode  <= 1'b0;
    end else if (bus.clr) begin
      q_r   <= '0;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      tc_r <= term_evt;
      if (accept) begin
        mode <= bus.oneshot;
      end
      if (bus.load) begin
        q_r <= load_val;
      end else if (step) begin
        if (at_term) begin
          // One-shot holds at the terminal value; free-run wraps within 0..MODULUS-1.
          if (!mode) begin
            q_r   <= bus.up ? '0 : MAX_VAL;
            ovf_r <= 1'b1;
          end
        end else begin
          q_r <= bus.up ? q_r + WIDTH'(1) : q_r - WIDTH'(1);
        end
      end
    end
  end

  assign bus.q    = q_r;
  assign bus.tc   = tc_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_c;

endmodule

// File: tb/tb_modn_updown_counter.sv
// Directed bench for modn_updown_counter: a MODULUS=10 instance for most scenarios
// and a MODULUS=16 instance for the full-width wrap.
module tb_modn_updown_counter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  modn_updown_counter_if #(.WIDTH(4)) bus_a ();
  modn_updown_counter_if #(.WIDTH(4)) bus_b ();

  modn_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  modn_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.clr = 0; bus_a.load = 0; bus_a.din = 0; bus_a.t = 0;
    bus_a.up = 1; bus_a.oneshot = 0; bus_a.start = 0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle_a();
    bus_b.clr = 0; bus_b.load = 0; bus_b.din = 0; bus_b.t = 0;
    bus_b.up = 1; bus_b.oneshot = 0; bus_b.start = 0;

    // Reset values without any clock edge
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    chk("rst_q", bus_a.q, 0);
    chk("rst_tc", bus_a.tc, 0);
    chk("rst_ovf", bus_a.ovf, 0);
    chk("rst_busy", bus_a.busy, 0);
    #6 reset = 1'b1;
    tick();

    // 1: free-run up, MODULUS=10, 12 steps
    bus_a.start = 1; bus_a.oneshot = 0; bus_a.up = 1;
    tick();
    chk("t1_busy_start", bus_a.busy, 1);
    chk("t1_q_start", bus_a.q, 0);
    bus_a.start = 0; bus_a.t = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk($sformatf("t1_q%0d", i), bus_a.q, i % 10);
      chk($sformatf("t1_tc%0d", i), bus_a.tc, (i == 10) ? 1 : 0);
      chk($sformatf("t1_busy%0d", i), bus_a.busy, 1);
    end
    chk("t1_ovf", bus_a.ovf, 1);

    // 6: direction change mid-run from q=2
    bus_a.up = 0;
    begin
      int exp_q[4] = '{1, 0, 9, 8};
      int exp_tc[4] = '{0, 0, 1, 0};
      for (int i = 0; i < 4; i++) begin
        tick();
        chk($sformatf("t6_q%0d", i), bus_a.q, exp_q[i]);
        chk($sformatf("t6_tc%0d", i), bus_a.tc, exp_tc[i]);
      end
    end
    chk("t6_ovf", bus_a.ovf, 1);

    // 4: clr overrides load, t and start
    bus_a.t = 0; bus_a.load = 1; bus_a.din = 5;
    tick();
    chk("t4_q_pre", bus_a.q, 5);
    chk("t4_ovf_pre", bus_a.ovf, 1);
    bus_a.clr = 1; bus_a.din = 7; bus_a.t = 1; bus_a.start = 1;
    tick();
    chk("t4_q", bus_a.q, 0);
    chk("t4_ovf", bus_a.ovf, 0);
    chk("t4_busy", bus_a.busy, 0);
    chk("t4_tc", bus_a.tc, 0);
    idle_a();

    // 3: saturating load
    bus_a.load = 1; bus_a.din = 12;
    tick();
    chk("t3_ld12", bus_a.q, 9);
    bus_a.din = 15;
    tick();
    chk("t3_ld15", bus_a.q, 9);
    bus_a.din = 4;
    tick();
    chk("t3_ld4", bus_a.q, 4);
    idle_a();

    // 2: load din=3 together with one-shot start, count down
    bus_a.load = 1; bus_a.din = 3; bus_a.start = 1; bus_a.oneshot = 1;
    tick();
    chk("t2_q_ld", bus_a.q, 3);
    chk("t2_busy_ld", bus_a.busy, 1);
    idle_a();
    bus_a.up = 0; bus_a.t = 1;
    begin
      int exp_q[6]    = '{2, 1, 0, 0, 0, 0};
      int exp_tc[6]   = '{0, 0, 0, 1, 0, 0};
      int exp_busy[6] = '{1, 1, 1, 0, 0, 0};
      for (int i = 0; i < 6; i++) begin
        tick();
        chk($sformatf("t2_q%0d", i), bus_a.q, exp_q[i]);
        chk($sformatf("t2_tc%0d", i), bus_a.tc, exp_tc[i]);
        chk($sformatf("t2_busy%0d", i), bus_a.busy, exp_busy[i]);
      end
    end
    chk("t2_ovf", bus_a.ovf, 0);
    idle_a();

    // 5: asynchronous reset mid-run
    bus_a.load = 1; bus_a.din = 6; bus_a.start = 1;
    tick();
    chk("t5_q_pre", bus_a.q, 6);
    chk("t5_busy_pre", bus_a.busy, 1);
    idle_a();
    #2 reset = 1'b0;
    #1;
    chk("t5_q_async", bus_a.q, 0);
    chk("t5_busy_async", bus_a.busy, 0);
    @(negedge clk);
    reset = 1'b1;
    bus_a.t = 1; bus_a.up = 1;
    tick();
    tick();
    chk("t5_q_nostart", bus_a.q, 0);
    chk("t5_busy_nostart", bus_a.busy, 0);
    bus_a.start = 1;
    tick();
    chk("t5_q_start", bus_a.q, 0);
    bus_a.start = 0;
    tick();
    chk("t5_q_count", bus_a.q, 1);
    idle_a();

    // MODULUS=16 wraps 15 -> 0 and loads 15 unsaturated
    bus_b.load = 1; bus_b.din = 14; bus_b.start = 1;
    tick();
    chk("m16_q14", bus_b.q, 14);
    bus_b.load = 0; bus_b.start = 0; bus_b.t = 1;
    tick();
    chk("m16_q15", bus_b.q, 15);
    tick();
    chk("m16_q0", bus_b.q, 0);
    chk("m16_tc", bus_b.tc, 1);
    chk("m16_ovf", bus_b.ovf, 1);
    bus_b.t = 0; bus_b.load = 1; bus_b.din = 15;
    tick();
    chk("m16_ld15", bus_b.q, 15);
    chk("m16_tc_ld", bus_b.tc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
